// File: rtl/croc_pkg.sv
// rtl/croc_pkg.sv - shared croc bus types and OBI-to-regbus bridge defaults
package croc_pkg;

  localparam int unsigned SbrObiIdWidth = 4;

  localparam int unsigned RegBridgeTimeout  = 64;
  localparam logic [31:0] RegBridgeErrRdata = 32'hBADC_AB1E;

  typedef struct packed {
    logic [31:0]              addr;
    logic                     we;
    logic [3:0]               be;
    logic [31:0]              wdata;
    logic [SbrObiIdWidth-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]              rdata;
    logic [SbrObiIdWidth-1:0] rid;
    logic                     err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/obi_reg_bridge.sv
// rtl/obi_reg_bridge.sv - single-outstanding OBI subordinate to regbus bridge with wait timeout
module obi_reg_bridge
  import croc_pkg::*;
#(
  parameter int unsigned TimeoutCycles = RegBridgeTimeout,
  parameter logic [31:0] ErrRdata      = RegBridgeErrRdata
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output reg_req_t     reg_req_o,
  input  reg_rsp_t     reg_rsp_i,
  output logic         busy_o
);

  localparam int unsigned    CntW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit             TimeoutEn = (TimeoutCycles > 0);
  localparam logic [CntW-1:0] CntLast  = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [31:0]              addr_q, addr_d;
  logic                     we_q, we_d;
  logic [3:0]               be_q, be_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [SbrObiIdWidth-1:0] aid_q, aid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aid_d     = aid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    obi_rsp_o = '0;
    reg_req_o = '0;

    unique case (state_q)
      StIdle: begin
        // gnt is masked by reset so nothing is granted while the flops are held
        obi_rsp_o.gnt = obi_req_i.req & rst_ni;
        if (obi_req_i.req) begin
          addr_d  = {obi_req_i.a.addr[31:2], 2'b00};
          we_d    = obi_req_i.a.we;
          be_d    = obi_req_i.a.be;
          wdata_d = obi_req_i.a.wdata;
          aid_d   = obi_req_i.a.aid;
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = addr_q;
        reg_req_o.write = we_q;
        reg_req_o.wdata = wdata_q;
        reg_req_o.wstrb = be_q;
        // ready has priority over a timeout expiring in the same cycle
        if (reg_rsp_i.ready) begin
          rdata_d = we_q ? 32'h0 : reg_rsp_i.rdata;
          err_d   = reg_rsp_i.error;
          cnt_d   = '0;
          state_d = StResp;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          rdata_d = we_q ? 32'h0 : ErrRdata;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StResp;
        end else if (cnt_q != {CntW{1'b1}}) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        obi_rsp_o.rvalid  = 1'b1;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = aid_q;
        obi_rsp_o.r.err   = err_q;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      aid_q   <= aid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q != StIdle);

endmodule

// File: doc/obi_reg_bridge.md
OBI_REG_BRIDGE -- requirements
Module: obi_reg_bridge

Interface
REQ-001 Parameter TimeoutCycles, default 64, regbus wait limit in cycles; 0 disables the timeout.
REQ-002 Parameter ErrRdata, default 32'hBADC_AB1E, rdata returned on a timed-out read.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 obi_req_i  in  sbr_obi_req_t  OBI subordinate request from the crossbar (32b addr/data, 4b be, SbrObiCfg.IdWidth aid).
REQ-006 obi_rsp_o  out  sbr_obi_rsp_t  OBI subordinate response (gnt, rvalid, rdata, rid, err); UseRReady=0, so there is no rready.
REQ-007 reg_req_o  out  reg_req_t  regbus request (addr, write, wdata, wstrb, valid).
REQ-008 reg_rsp_i  in  reg_rsp_t  regbus response (rdata, error, ready).
REQ-009 busy_o  out  1  high whenever the FSM is not IDLE.

Function
REQ-010 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-011 IDLE: obi_rsp_o.gnt = obi_req_i.req (combinational); all other states: gnt = 0.
REQ-012 A handshake (req & gnt) SHALL latch addr, we, be, wdata and aid, then move the FSM to ACCESS.
REQ-013 The latched addr SHALL have addr[1:0] forced to 0.
REQ-014 ACCESS: reg_req_o.valid = 1, addr/write/wdata/wstrb = latched values (wstrb = be); these are held stable until ready or timeout.
REQ-015 ACCESS with reg_rsp_i.ready = 1: latch rdata (0 if write) and error, clear the timeout counter, go to RESP.
REQ-016 Timeout counter: increments each ACCESS cycle with ready = 0.
REQ-017 When the counter reaches TimeoutCycles-1 with ready still 0 (TimeoutCycles > 0): latch err = 1 and rdata = ErrRdata (0 if write), deassert valid next cycle, go to RESP.
REQ-018 If ready and timeout coincide, ready wins: normal response, err = reg_rsp_i.error.
REQ-019 RESP: obi_rsp_o.rvalid = 1 for exactly one cycle, with rid = latched aid, rdata, err; then return to IDLE.
REQ-020 Latency: gnt in cycle N, reg valid in N+1, ready earliest in N+1, rvalid in N+2; a new gnt is possible in N+3.
REQ-021 Outside RESP: rvalid = 0; rdata, rid and err are driven 0.
REQ-022 Outside ACCESS: reg_req_o is all-zero.
REQ-023 At most one transaction is outstanding; req held in ACCESS/RESP SHALL be stalled (gnt = 0) without loss.
REQ-024 Counter width SHALL be $clog2(TimeoutCycles+1), min 1; the counter SHALL NOT wrap while in ACCESS.

Reset
REQ-025 rst_ni low SHALL immediately force the FSM to IDLE, clear all latches and the counter, and drive gnt, rvalid, reg_req_o.valid and busy_o to 0.
REQ-026 Reset mid-ACCESS or mid-RESP SHALL abort the transaction with no rvalid afterwards; the first gnt is possible in the first cycle after release.

Structure
REQ-027 Types sbr_obi_req_t, sbr_obi_rsp_t, reg_req_t and reg_rsp_t SHALL come from croc_pkg; the block defines no new structs.
REQ-028 The default constants RegBridgeTimeout (64) and RegBridgeErrRdata (32'hBADC_AB1E) SHALL be added to croc_pkg and used as the parameter defaults.
REQ-029 The block is one flat module (FSM, latch register, counter); no sub-module.

Verification
REQ-030 Write, addr 0x0300_2006, wdata 0x1234_5678, be 4'b0011, aid 3, ready in the first ACCESS cycle -> reg addr 0x0300_2004, wstrb 0011; rvalid at N+2 with rid 3, err 0, rdata 0.
REQ-031 Read, addr 0x0300_5000, ready after 5 cycles with rdata 0xCAFE_F00D, error 1 -> valid held stable 6 cycles; rvalid one cycle with rdata 0xCAFE_F00D, err 1.
REQ-032 TimeoutCycles = 4, read, ready never asserted -> valid for 4 cycles then 0; rvalid with err 1, rdata 0xBADC_AB1E; next transaction completes normally.
REQ-033 Back-to-back req held high for 3 transactions with immediate ready -> gnt at cycles 0, 3, 6; three rvalid pulses with matching rids; no request lost.
REQ-034 rst_ni pulsed low during ACCESS -> all outputs 0 asynchronously; no rvalid after release; a following read completes in 3 cycles.
REQ-035 TimeoutCycles = 4, ready asserted on the 4th ACCESS cycle (same cycle as timeout) -> err = reg error (0), rdata = reg rdata.
